// File: rtl/data_memory_responder_if.sv
// Data memory request/response bus between the MEM pipeline stage and the responder.
//
// Signals:
//   mem_read    - load request
//   mem_write   - store request
//   address     - byte address
//   write_data  - store data, right-aligned
//   size        - 00 byte, 01 halfword, 10 word, 11 illegal
//   is_unsigned - 1 zero-extends, 0 sign-extends sub-word loads
//   read_data   - extended load result, meaningful only while ready is high
//   ready       - one-cycle response pulse
//   stall       - pipeline must hold its MEM-stage request
//   error       - request was rejected, meaningful only while ready is high
//
// Modports: master is the pipeline side, slave is the responder side.
interface data_memory_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] read_data;
    logic        ready;
    logic        stall;
    logic        error;

    modport master (
        output mem_read,
        output mem_write,
        output address,
        output write_data,
        output size,
        output is_unsigned,
        input  read_data,
        input  ready,
        input  stall,
        input  error
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  address,
        input  write_data,
        input  size,
        input  is_unsigned,
        output read_data,
        output ready,
        output stall,
        output error
    );
endinterface

// File: rtl/data_memory_responder.sv
// Fixed-latency data memory responder for a pipelined CPU's MEM stage.
//
// A request (mem_read | mem_write) is accepted only in IDLE; the request fields are latched,
// the FSM waits LATENCY clock edges, then presents a one-cycle response in RESP. Stores
// commit on the edge entering RESP; loads are read from the array during RESP and
// zero/sign-extended. Misaligned, illegal-size and read+write requests are answered with
// error=1, leave memory untouched and return zero data.
//
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous active-high reset (memory array contents are not cleared)
//   bus - slave side of data_memory_responder_if
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input logic                    clk,
    input logic                    rst,
    data_memory_responder_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Latched request
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          req;
    logic          accept;

    // Fields of the request being serviced: live inputs while idle, latched copy otherwise.
    // With LATENCY=1 the store commits on the acceptance edge itself, before the latch holds it.
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic          cur_rd;
    logic          cur_wr;
    logic          cur_err;

    logic          mem_we;
    logic [31:0]   mem_wdata;

    logic          lat_err;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_ext;

    // Higher address bits wrap away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[31:AW+2];

    assign req = bus.mem_read | bus.mem_write;

    function automatic logic req_error(input logic rd, input logic wr, input logic [1:0] sz,
                                       input logic [1:0] lo);
        logic e;
        e = (rd & wr) | (sz == 2'b11) | ((sz == 2'b01) & lo[0]) | ((sz == 2'b10) & (lo != 2'b00));
        return e;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntW'(LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Request latch
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (accept) begin
            addr_d  = bus.address[AW+1:0];
            wdata_d = bus.write_data;
            size_d  = bus.size;
            uns_d   = bus.is_unsigned;
            rd_d    = bus.mem_read;
            wr_d    = bus.mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Store path
    always_comb begin
        if (state_q == StIdle) begin
            cur_addr  = bus.address[AW+1:0];
            cur_wdata = bus.write_data;
            cur_size  = bus.size;
            cur_rd    = bus.mem_read;
            cur_wr    = bus.mem_write;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
            cur_rd    = rd_q;
            cur_wr    = wr_q;
        end
        cur_err = req_error(cur_rd, cur_wr, cur_size, cur_addr[1:0]);

        // Gated by rst so a held reset with LATENCY=1 cannot sneak a write in.
        mem_we = ~rst & (state_d == StResp) & (state_q != StResp) & cur_wr & ~cur_rd & ~cur_err;

        // Merge only the addressed lanes into the existing word.
        mem_wdata = mem_q[cur_addr[AW+1:2]];
        case (cur_size)
            2'b00:   mem_wdata[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
            2'b01:   mem_wdata[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
            default: mem_wdata = cur_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cur_addr[AW+1:2]] <= mem_wdata;
        end
    end

    // Load path, evaluated from the latched request during RESP
    always_comb begin
        lat_err = req_error(rd_q, wr_q, size_q, addr_q[1:0]);
        rd_word = mem_q[addr_q[AW+1:2]];
        rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
        rd_half = rd_word[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   rd_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: rd_ext = rd_word;
        endcase
    end

    // Outputs: all response fields are qualified by RESP, so async reset clears them at once.
    assign bus.ready     = (state_q == StResp);
    assign bus.error     = (state_q == StResp) & lat_err;
    assign bus.read_data = ((state_q == StResp) & rd_q & ~wr_q & ~lat_err) ? rd_ext : 32'h0;
    assign bus.stall     = ((state_q == StIdle) & req) | (state_q == StBusy);

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios followed by randomized
// traffic checked against a byte-array reference model.
module tb_data_memory_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned BYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_responder_if bus();

    data_memory_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [BYTES];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed little-endian memory, wrapping modulo BYTES.
    task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                         output logic [31:0] exp_rd, output logic exp_err);
        int unsigned b;
        int unsigned n;
        logic [31:0] v;
        b = a % BYTES;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp_err = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                  (sz == 2'd2 && a[1:0] != 2'b00);
        exp_rd = 32'h0;
        if (!exp_err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) mdl[b + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[b + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                exp_rd = v;
            end
        end
    endtask

    task automatic junk_inputs();
        bus.mem_read    = 1'($urandom);
        bus.mem_write   = 1'($urandom);
        bus.address     = $urandom;
        bus.write_data  = $urandom;
        bus.size        = 2'($urandom);
        bus.is_unsigned = 1'($urandom);
    endtask

    // One full transaction; starts with the DUT idle and returns with it idle.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                         input string tag, output logic [31:0] got, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        model(rd, wr, a, wd, sz, uns, exp_rd, exp_err);
        bus.mem_read    = rd;
        bus.mem_write   = wr;
        bus.address     = a;
        bus.write_data  = wd;
        bus.size        = sz;
        bus.is_unsigned = uns;
        #1;
        chk({tag, "_stall_req"}, 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        n = 0;
        // Inputs are scrambled while the request is in flight; the latched copy must be used.
        junk_inputs();
        #0;
        while (!bus.ready && n < int'(LAT) + 3) begin
            if (n < int'(LAT)) chk({tag, "_stall_busy"}, 32'(bus.stall), 32'd1);
            @(posedge clk);
            #1;
            n++;
            junk_inputs();
            #1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT));
        got     = bus.read_data;
        got_err = bus.error;
        chk({tag, "_stall_resp"}, 32'(bus.stall), 32'd0);
        chk({tag, "_error"}, 32'(bus.error), 32'(exp_err));
        chk({tag, "_rdata"}, bus.read_data, exp_rd);
        @(posedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        chk({tag, "_ready_drop"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int unsigned k;
        logic [31:0] a;
        logic        rdy_seen;

        rst             = 1'b1;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.address     = '0;
        bus.write_data  = '0;
        bus.size        = '0;
        bus.is_unsigned = 1'b0;
        #2;
        chk("reset_ready", 32'(bus.ready), 32'd0);
        chk("reset_stall", 32'(bus.stall), 32'd0);
        chk("reset_error", 32'(bus.error), 32'd0);
        chk("reset_rdata", bus.read_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Word store then load; first request accepted on the first edge after reset release
        do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, "sw10", r, e);
        chk("sw10_err", 32'(e), 32'd0);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "lw10", r, e);
        chk("lw10_val", r, 32'hDEADBEEF);

        // Sub-word extension
        do_op(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, "lb11", r, e);
        chk("lb11_val", r, 32'hFFFFFFBE);
        do_op(1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b1, "lbu11", r, e);
        chk("lbu11_val", r, 32'h000000BE);
        do_op(1'b1, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, "lh12", r, e);
        chk("lh12_val", r, 32'hFFFFDEAD);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 2'd1, 1'b1, "lhu10", r, e);
        chk("lhu10_val", r, 32'h0000BEEF);

        // Partial store merge
        do_op(1'b0, 1'b1, 32'h13, 32'h00000055, 2'd0, 1'b0, "sb13", r, e);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "lw10b", r, e);
        chk("lw10b_val", r, 32'h55ADBEEF);
        do_op(1'b0, 1'b1, 32'h10, 32'h00001234, 2'd1, 1'b0, "sh10", r, e);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "lw10c", r, e);
        chk("lw10c_val", r, 32'h55AD1234);

        // Error cases
        do_op(1'b1, 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, "lw12", r, e);
        chk("lw12_err", 32'(e), 32'd1);
        chk("lw12_data", r, 32'd0);
        do_op(1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 2'd2, 1'b0, "sw11", r, e);
        chk("sw11_err", 32'(e), 32'd1);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "lw10d", r, e);
        chk("lw10d_val", r, 32'h55AD1234);
        do_op(1'b1, 1'b1, 32'h10, 32'h12345678, 2'd2, 1'b0, "rdwr", r, e);
        chk("rdwr_err", 32'(e), 32'd1);

        // Address wrap
        do_op(1'b0, 1'b1, 32'h404, 32'hCAFEF00D, 2'd2, 1'b0, "sw404", r, e);
        do_op(1'b1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, "lw4", r, e);
        chk("lw4_val", r, 32'hCAFEF00D);

        // Reset during BUSY aborts a pending store
        do_op(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 2'd2, 1'b0, "sw20", r, e);
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.address    = 32'h20;
        bus.write_data = 32'h11111111;
        bus.size       = 2'd2;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        #1;
        chk("abort_stall_busy", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_error", 32'(bus.error), 32'd0);
        chk("abort_rdata", bus.read_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rdy_seen = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clk);
            #1;
            if (bus.ready) rdy_seen = 1'b1;
        end
        chk("abort_no_ready", 32'(rdy_seen), 32'd0);
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, "lw20", r, e);
        chk("lw20_val", r, 32'hA5A5A5A5);

        // Randomized traffic over an initialised window, with random high address bits
        for (int w = 0; w < 16; w++) begin
            do_op(1'b0, 1'b1, 32'h40 + 32'(4 * w), $urandom, 2'd2, 1'b0, "init", r, e);
        end
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            a = ($urandom & 32'hFFFF_FC00) | (32'h40 + 32'($urandom_range(0, 63)));
            do_op((k == 0) || (k >= 5), (k <= 4), a, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom), "rand", r, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit memory words (power of two).
REQ-002 Parameter LATENCY, default 2, SHALL set the number of clock edges from request acceptance to response (minimum 1).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be asynchronous, active-high.
REQ-005 MemRead  input  1  SHALL be the read request from the MEM stage.
REQ-006 MemWrite  input  1  SHALL be the write request from the MEM stage.
REQ-007 Address  input  32  SHALL be the byte address.
REQ-008 WriteData  input  32  SHALL be the store data, right-aligned.
REQ-009 Size  input  2  SHALL encode access width: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 Unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) for sub-word loads.
REQ-011 ReadData  output  32  SHALL be the extended load result, valid only while Ready is high.
REQ-012 Ready  output  1  SHALL be a one-cycle response pulse.
REQ-013 Stall  output  1  SHALL tell the pipeline to hold its MEM-stage request.
REQ-014 Error  output  1  SHALL flag a rejected request, valid only while Ready is high.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY, and RESP.
REQ-016 A request is MemRead|MemWrite; it SHALL be accepted only on an edge where the state is IDLE.
- Accepting it SHALL latch Address, WriteData, Size, Unsigned, and the request type.
- It SHALL enter BUSY with a counter of LATENCY-1, or RESP directly when LATENCY=1.
REQ-017 In BUSY the counter SHALL decrement each edge; at zero the next edge SHALL enter RESP.
REQ-018 RESP SHALL last exactly one cycle with Ready=1, then return to IDLE.
- Requests are not accepted in RESP, so back-to-back requests have a one-cycle bubble.
REQ-019 Ready SHALL be high exactly in the cycle following the LATENCY-th edge after the acceptance edge.
REQ-020 Stall SHALL be combinational: 1 when (IDLE and request present) or in BUSY; 0 in RESP and in IDLE without a request.
REQ-021 Inputs in BUSY and RESP SHALL be ignored; the latched copy is used.
REQ-022 Word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-023 Byte order SHALL be little-endian: a byte at Address[1:0]=k occupies bits [8k+7:8k].
REQ-024 Loads SHALL behave as follows:
- Byte loads SHALL select the lane by Address[1:0].
- Halfword loads SHALL select the lane by Address[1].
- Results SHALL be zero- or sign-extended per Unsigned; word loads ignore Unsigned.
REQ-025 Stores SHALL modify only the addressed byte/halfword lanes, leaving other bytes of the word unchanged.
REQ-026 The write SHALL commit on the edge entering RESP, so a later read returns the new data.
REQ-027 Error SHALL be 1 in RESP when the latched request had any of:
- MemRead and MemWrite both high;
- Size=11;
- a halfword with Address[0]=1;
- a word with Address[1:0]!=00.
REQ-028 On Error, memory SHALL NOT be modified and ReadData SHALL be 0.
REQ-029 For a write response, ReadData SHALL be 0.
REQ-030 Outside RESP, ReadData, Ready, and Error SHALL be 0.

Reset
REQ-031 Reset=1 SHALL immediately force state IDLE, counter 0, and Ready, Error, ReadData all 0, independent of Clk.
- Stall then follows REQ-020.
REQ-032 Reset asserted in BUSY SHALL abort the operation; a pending store SHALL NOT be committed.
REQ-033 Reset SHALL NOT clear the memory array; contents are undefined until written.
REQ-034 The first request SHALL be accepted on the first rising edge after Reset deasserts.

Verification
REQ-035 Word store, then load (LATENCY=2): store 0xDEADBEEF to 0x00000010 -> Stall high for 2 cycles, then Ready pulse with Error=0. Load 0x10 (Size=10) -> Ready 2 edges after acceptance, ReadData=0xDEADBEEF.
REQ-036 Sub-word extension, word 0x10 = 0xDEADBEEF:
- lb 0x11, Unsigned=0 -> 0xFFFFFFBE
- lbu 0x11 -> 0x000000BE
- lh 0x12 -> 0xFFFFDEAD
- lhu 0x10 -> 0x0000BEEF
REQ-037 Partial store merge: sb 0x55 to 0x13 over 0xDEADBEEF, then lw 0x10 -> 0x55ADBEEF. sh 0x1234 to 0x10, then lw -> 0x55AD1234.
REQ-038 Errors:
- lw at 0x12 -> Ready with Error=1, ReadData=0.
- sw 0xFFFFFFFF at 0x11 -> Error=1; a later lw 0x10 still returns the prior value.
- MemRead=MemWrite=1 -> Error=1.
REQ-039 Wrap: with DEPTH_WORDS=256, sw 0xCAFEF00D at 0x00000404, then lw 0x00000004 -> 0xCAFEF00D.
REQ-040 Reset mid-operation: issue sw 0x11111111 to 0x20, assert Reset during BUSY.
- Expected: Ready/Stall/Error drop immediately and no Ready pulse follows.
- After release, lw 0x20 SHALL return the pre-store contents.
